ste_master: RTL
===============

Name: ste_master

Overview:
- STEbus initiator for the VDU/Z180 side; the counterpart of the board's DATACK-generating slave responders.
- Takes single-byte read/write requests from a local host port and runs one STEbus cycle per request: drives ADR/CM/ADRSTB/DATSTB, waits for the responder's active-low DATACK, then releases the bus.
- Reports completion or error (timeout or TRFERR) back to the host.
- Bus-side inputs are asynchronous to clk and are synchronised internally.

Parameters:
ADDR_W, 20, STEbus address width.
ADDR_SETUP, 2, clk cycles ADRSTB is low before DATSTB is asserted (1..15).
TIMEOUT, 64, clk cycles in DATA state without DATACK before error (2..255).

Ports:
clk  in  1  16 MHz bus clock; all logic on posedge.
rst  in  1  asynchronous, active-high reset.
req  in  1  host request; sampled only in IDLE.
we  in  1  1 = write, 0 = read; latched with req.
io  in  1  1 = I/O space, 0 = memory; latched with req.
addr  in  ADDR_W  host address; latched with req.
wdata  in  8  write data; latched with req.
rdata  out  8  read data; valid from the done pulse until the next accepted req.
busy  out  1  high from the cycle after req is accepted until return to IDLE.
done  out  1  one-cycle pulse on successful completion.
err  out  1  one-cycle pulse on timeout or TRFERR; mutually exclusive with done.
ste_adr  out  ADDR_W  bus address.
ste_cm  out  3  command modifier: {1, ~io, ~we}.
  111 = mem read, 110 = mem write, 101 = io read, 100 = io write.
ste_dat_o  out  8  bus data out.
ste_dat_oe  out  1  data driver enable (writes only).
ste_dat_i  in  8  bus data in.
adrstb  out  1  address strobe, active low.
datstb  out  1  data strobe, active low.
datack  in  1  responder acknowledge, active low, asynchronous.
trferr  in  1  transfer error, active low, asynchronous.

Behaviour:
- Reset values:
  - adrstb = datstb = 1; ste_dat_oe = 0; busy = done = err = 0.
  - rdata, ste_adr and ste_dat_o = 0; ste_cm = 3'b111.
  - State = IDLE; sync flops preset to 1 (inactive).
- Synchronisers:
  - datack and trferr each pass through 2 flops; only the synced versions are used.
  - Acknowledge latency as seen by the FSM is therefore 2–3 clk.
- FSM states: IDLE, ADDR, DATA, RELEASE.
- IDLE, req = 1:
  - Latch addr, wdata, we and io.
  - Drive ste_adr, ste_cm and ste_dat_o from the latched values.
  - Set ste_dat_oe = we.
  - Next cycle: adrstb = 0, busy = 1, state = ADDR.
- ADDR:
  - Counter runs ADDR_SETUP cycles.
  - Then datstb = 0 and state = DATA; the timeout counter clears.
- DATA, each cycle:
  - Synced trferr = 0: err pulse.
  - Else synced datack = 0: capture ste_dat_i into rdata (reads only; rdata is unchanged on writes), done pulse.
  - Else the counter increments; if it reaches TIMEOUT-1, err pulse.
  - Any of these three events: same cycle set datstb = 1, adrstb = 1, ste_dat_oe = 0; state = RELEASE.
  - trferr and datack low in the same cycle: err wins, done is not pulsed, rdata is not updated.
- RELEASE:
  - Wait for synced datack = 1, then go to IDLE and drop busy.
  - ste_adr and ste_cm are held until IDLE is reached.
  - req is ignored outside IDLE.
  - Holding req high gives back-to-back cycles with one IDLE cycle between them.
- Reset mid-operation: strobes deassert and the data driver releases asynchronously; no done/err pulse is produced.
- Stuck responder: if datack never returns high after an ack, the master stays in RELEASE with busy = 1. This is intentional, to avoid bus contention.

Decomposition:
- Package ste_pkg holds:
  - State encoding: IDLE=0, ADDR=1, DATA=2, RELEASE=3.
  - CM constants: CM_MEM_RD, CM_MEM_WR, CM_IO_RD, CM_IO_WR.
  - Default ADDR_W.
- One sub-module, ste_sync2: 2-flop synchroniser with a reset-to-1 preset. It is instantiated twice (datack, trferr).

Test Plan:
- Memory write: addr = 20'h1A2B3, wdata = 8'h5C, responder acks 3 clk after datstb falls → ste_cm = 110, ste_dat_oe = 1 while strobes are low, done pulses once, err = 0, adrstb/datstb return to 1.
- I/O read: addr = 20'h00040, responder drives 8'hA7 and acks → ste_cm = 101, rdata = 8'hA7 on the done cycle, ste_dat_oe never 1.
- Timeout: TIMEOUT = 8, no datack → err pulses 8 cycles after datstb falls, strobes release the same cycle, busy drops one cycle later.
- Error precedence: trferr and datack pulled low together → err = 1, done = 0, rdata unchanged.
- Back-to-back: req held high for two writes → two done pulses, exactly one IDLE cycle between them; the second cycle starts only after datack returns high.
- Reset: rst asserted while in DATA → adrstb = datstb = 1 and ste_dat_oe = 0 immediately, no done/err, state = IDLE.

Source files
------------

// File: rtl/ste_pkg.sv
// ste_pkg: shared definitions for the STEbus initiator.
//   ste_state_t    - FSM state encoding (IDLE=0, ADDR=1, DATA=2, RELEASE=3)
//   CM_*           - STEbus command-modifier codes
//   STE_ADDR_W     - default STEbus address width
//   cm_encode()    - host io/we flags to command-modifier code
package ste_pkg;

  localparam int STE_ADDR_W = 20;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR    = 2'd1,
    DATA    = 2'd2,
    RELEASE = 2'd3
  } ste_state_t;

  localparam logic [2:0] CM_MEM_RD = 3'b111;
  localparam logic [2:0] CM_MEM_WR = 3'b110;
  localparam logic [2:0] CM_IO_RD  = 3'b101;
  localparam logic [2:0] CM_IO_WR  = 3'b100;

  function automatic logic [2:0] cm_encode(input logic io, input logic we);
    logic [2:0] cm;
    case ({io, we})
      2'b00:   cm = CM_MEM_RD;
      2'b01:   cm = CM_MEM_WR;
      2'b10:   cm = CM_IO_RD;
      default: cm = CM_IO_WR;
    endcase
    return cm;
  endfunction

endpackage

// File: rtl/ste_sync2.sv
// ste_sync2: two-flop synchroniser for an active-low asynchronous bus line.
//   clk - sampling clock
//   rst - asynchronous active-high reset; both flops preset to 1 (inactive)
//   d   - asynchronous input
//   q   - synchronised output
module ste_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ste_master.sv
// ste_master: STEbus initiator. Runs one single-byte bus cycle per host
// request and reports done or err back to the host.
//   host side : req, we, io, addr, wdata in; rdata, busy, done, err out
//   bus side  : ste_adr, ste_cm, ste_dat_o, ste_dat_oe, adrstb, datstb out;
//               ste_dat_i, datack, trferr in (asynchronous, active-low strobes)
// Parameters: ADDR_W address width, ADDR_SETUP clk cycles of ADRSTB before
// DATSTB, TIMEOUT clk cycles in DATA without acknowledge before err.
module ste_master
  import ste_pkg::*;
#(
  parameter int ADDR_W     = STE_ADDR_W,
  parameter int ADDR_SETUP = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic              io,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] ste_adr,
  output logic [2:0]        ste_cm,
  output logic [7:0]        ste_dat_o,
  output logic              ste_dat_oe,
  input  logic [7:0]        ste_dat_i,
  output logic              adrstb,
  output logic              datstb,
  input  logic              datack,
  input  logic              trferr
);

  localparam logic [7:0] SETUP_LAST = 8'(ADDR_SETUP - 1);
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

  ste_state_t        state, state_nxt;
  logic [7:0]        cnt, cnt_nxt;
  logic              datack_s, trferr_s;
  logic              adrstb_nxt, datstb_nxt, oe_nxt, busy_nxt, done_nxt, err_nxt;
  logic [ADDR_W-1:0] adr_nxt;
  logic [2:0]        cm_nxt;
  logic [7:0]        dato_nxt, rdata_nxt;
  logic              ack_evt, terr_evt, to_evt;

  ste_sync2 u_sync_datack (.clk(clk), .rst(rst), .d(datack), .q(datack_s));
  ste_sync2 u_sync_trferr (.clk(clk), .rst(rst), .d(trferr), .q(trferr_s));

  // trferr takes precedence over datack; the timeout only fires when neither
  // is seen this cycle.
  assign terr_evt = !trferr_s;
  assign ack_evt  = trferr_s && !datack_s;
  assign to_evt   = trferr_s && datack_s && (cnt == TO_LAST);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    adrstb_nxt = adrstb;
    datstb_nxt = datstb;
    oe_nxt     = ste_dat_oe;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    adr_nxt    = ste_adr;
    cm_nxt     = ste_cm;
    dato_nxt   = ste_dat_o;
    rdata_nxt  = rdata;
    case (state)
      IDLE: begin
        if (req) begin
          adr_nxt    = addr;
          cm_nxt     = cm_encode(io, we);
          dato_nxt   = wdata;
          oe_nxt     = we;
          adrstb_nxt = 1'b0;
          busy_nxt   = 1'b1;
          cnt_nxt    = '0;
          state_nxt  = ADDR;
        end
      end
      ADDR: begin
        if (cnt == SETUP_LAST) begin
          datstb_nxt = 1'b0;
          cnt_nxt    = '0;
          state_nxt  = DATA;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      DATA: begin
        if (terr_evt || ack_evt || to_evt) begin
          err_nxt    = terr_evt || to_evt;
          done_nxt   = ack_evt;
          // ste_cm[0] set means a read; the responder has held the data
          // stable since before its acknowledge, so the synced ack
          // guarantees ste_dat_i has settled.
          if (ack_evt && ste_cm[0])
            rdata_nxt = ste_dat_i;
          datstb_nxt = 1'b1;
          adrstb_nxt = 1'b1;
          oe_nxt     = 1'b0;
          state_nxt  = RELEASE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      RELEASE: begin
        // Wait for the responder to drop its acknowledge before reusing the bus.
        if (datack_s) begin
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      adrstb     <= 1'b1;
      datstb     <= 1'b1;
      ste_dat_oe <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      ste_adr    <= '0;
      ste_cm     <= CM_MEM_RD;
      ste_dat_o  <= '0;
      rdata      <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      adrstb     <= adrstb_nxt;
      datstb     <= datstb_nxt;
      ste_dat_oe <= oe_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
      ste_adr    <= adr_nxt;
      ste_cm     <= cm_nxt;
      ste_dat_o  <= dato_nxt;
      rdata      <= rdata_nxt;
    end
  end

endmodule
